// File: rtl/ifs1p3_deser_align_if.sv
// Bus bundle for the serial-in / parallel-out receive aligner.
// The pad side drives D/SP/ALIGN_REQ; the aligner returns the word and status.
interface ifs1p3_deser_align_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SCW = $clog2(WIDTH);

  logic             D;
  logic             SP;
  logic             ALIGN_REQ;
  logic [WIDTH-1:0] Q;
  logic             QVALID;
  logic             LOCKED;
  logic             ERR;
  logic [SCW-1:0]   SLIP_CNT;

  modport master (
    output D, SP, ALIGN_REQ,
    input  Q, QVALID, LOCKED, ERR, SLIP_CNT
  );

  modport slave (
    input  D, SP, ALIGN_REQ,
    output Q, QVALID, LOCKED, ERR, SLIP_CNT
  );
endinterface

// File: rtl/ifs1p3_deser_align.sv
// Serial-to-parallel receive aligner: MSB-first deserialiser that bit-slips its
// word boundary until ALIGN_PAT is seen LOCK_CNT times in a row.
module ifs1p3_deser_align #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] ALIGN_PAT = 8'hA5,
  parameter int unsigned      LOCK_CNT  = 4,
  parameter                   GSR       = "ENABLED"
) (
  input  logic                 SCLK,
  input  logic                 SRN,
  ifs1p3_deser_align_if.slave  bus
);
  localparam int unsigned SCW = $clog2(WIDTH);
  localparam int unsigned MCW = $clog2(LOCK_CNT + 1);
  localparam bit          GSR_EN = (GSR == "ENABLED");

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HUNT    = 2'd1;
  localparam logic [1:0] ST_CONFIRM = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  // The device global set/reset net is inactive (high) outside the device library.
  logic gsr_net_s;
  logic rst_n_s;
  assign gsr_net_s = 1'b1;
  assign rst_n_s   = GSR_EN ? (SRN & gsr_net_s) : SRN;

  logic [WIDTH-2:0] sr_q, sr_d;
  logic [SCW-1:0]   bc_q, bc_d;
  logic [MCW-1:0]   mc_q, mc_d;
  logic [SCW-1:0]   slip_cnt_q, slip_cnt_d;
  logic             slip_pend_q, slip_pend_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qvalid_q, qvalid_d;
  logic             locked_q, locked_d;
  logic [1:0]       state_q, state_d;

  logic [WIDTH-1:0] word_s;
  logic             done_s;
  logic             match_s;
  logic             do_slip_s;
  logic [MCW-1:0]   mc_inc_s;

  // Next-state logic: shift/count, word completion, alignment FSM and slip bookkeeping.
  always_comb begin
    sr_d        = sr_q;
    bc_d        = bc_q;
    mc_d        = mc_q;
    slip_cnt_d  = slip_cnt_q;
    slip_pend_d = slip_pend_q;
    err_d       = err_q;
    q_d         = q_q;
    qvalid_d    = 1'b0;
    state_d     = state_q;
    do_slip_s   = 1'b0;
    word_s      = {sr_q, bus.D};
    match_s     = (word_s == ALIGN_PAT);
    mc_inc_s    = mc_q + MCW'(1);
    done_s      = bus.SP && !slip_pend_q && (bc_q == SCW'(WIDTH - 1));

    // A pending slip consumes one extra beat with the bit counter parked at 0.
    if (bus.SP) begin
      sr_d = word_s[WIDTH-2:0];
      if (slip_pend_q) begin
        bc_d        = '0;
        slip_pend_d = 1'b0;
      end else if (done_s) begin
        bc_d = '0;
      end else begin
        bc_d = bc_q + SCW'(1);
      end
    end else begin
      sr_d = sr_q;
    end

    if (bus.ALIGN_REQ) begin
      state_d    = ST_HUNT;
      slip_cnt_d = '0;
      mc_d       = '0;
      err_d      = 1'b0;
      if (done_s) begin
        q_d = word_s;
      end else begin
        q_d = q_q;
      end
    end else if (done_s) begin
      q_d = word_s;
      case (state_q)
        ST_IDLE:   qvalid_d = 1'b1;
        ST_LOCKED: qvalid_d = 1'b1;
        ST_HUNT: begin
          if (match_s) begin
            mc_d    = MCW'(1);
            state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_CONFIRM;
          end else begin
            do_slip_s = 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (match_s) begin
            mc_d    = mc_inc_s;
            state_d = (mc_inc_s == MCW'(LOCK_CNT)) ? ST_LOCKED : ST_CONFIRM;
          end else begin
            mc_d      = '0;
            state_d   = ST_HUNT;
            do_slip_s = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    // SLIP_CNT wraps modulo WIDTH; a full lap without a match is an error.
    if (do_slip_s) begin
      slip_pend_d = 1'b1;
      if (slip_cnt_q == SCW'(WIDTH - 1)) begin
        slip_cnt_d = '0;
        err_d      = 1'b1;
      end else begin
        slip_cnt_d = slip_cnt_q + SCW'(1);
      end
    end else begin
      slip_pend_d = slip_pend_d;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge SCLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sr_q        <= '0;
      bc_q        <= '0;
      mc_q        <= '0;
      slip_cnt_q  <= '0;
      slip_pend_q <= 1'b0;
      err_q       <= 1'b0;
      q_q         <= '0;
      qvalid_q    <= 1'b0;
      locked_q    <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      sr_q        <= sr_d;
      bc_q        <= bc_d;
      mc_q        <= mc_d;
      slip_cnt_q  <= slip_cnt_d;
      slip_pend_q <= slip_pend_d;
      err_q       <= err_d;
      q_q         <= q_d;
      qvalid_q    <= qvalid_d;
      locked_q    <= locked_d;
      state_q     <= state_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.QVALID   = qvalid_q;
  assign bus.LOCKED   = locked_q;
  assign bus.ERR      = err_q;
  assign bus.SLIP_CNT = slip_cnt_q;
endmodule

// File: tb/tb_ifs1p3_deser_align.sv
// Directed bench for ifs1p3_deser_align (WIDTH=8, ALIGN_PAT=A5, LOCK_CNT=4):
// passthrough, gapped SP, alignment, collision, no-pattern error and async reset.
module tb_ifs1p3_deser_align;
  logic SCLK;
  logic SRN;
  logic clk_en;
  int   checks;
  int   failures;

  ifs1p3_deser_align_if #(.WIDTH(8)) bus_if ();

  ifs1p3_deser_align #(
    .WIDTH     (8),
    .ALIGN_PAT (8'hA5),
    .LOCK_CNT  (4),
    .GSR       ("ENABLED")
  ) dut (
    .SCLK (SCLK),
    .SRN  (SRN),
    .bus  (bus_if)
  );

  always begin
    #5;
    if (clk_en) SCLK = ~SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic d, input logic sp, input logic areq);
    bus_if.D         = d;
    bus_if.SP        = sp;
    bus_if.ALIGN_REQ = areq;
    @(posedge SCLK);
    #1;
  endtask

  // Sends one word MSB-first; gap inserts an SP=0 beat after every bit.
  task automatic send_word(input logic [7:0] w, input bit gap, input string tag);
    for (int i = 0; i < 8; i++) begin
      beat(w[7-i], 1'b1, 1'b0);
      if (i < 7) begin
        chk({tag, "_qvalid_mid"}, {31'd0, bus_if.QVALID}, 32'd0);
      end else begin
        chk({tag, "_qvalid_end"}, {31'd0, bus_if.QVALID}, 32'd1);
        chk({tag, "_q"}, {24'd0, bus_if.Q}, {24'd0, w});
      end
      if (gap) begin
        beat(1'b0, 1'b0, 1'b0);
        chk({tag, "_qvalid_gap"}, {31'd0, bus_if.QVALID}, 32'd0);
        if (i == 7) chk({tag, "_q_hold"}, {24'd0, bus_if.Q}, {24'd0, w});
      end
    end
  endtask

  // A5 repeating, with its true boundary three bits after the receiver's.
  function automatic logic t3_bit(input int n);
    logic [7:0] p;
    p = 8'hA5;
    if (n < 3) return 1'b0;
    return p[7 - ((n - 3) % 8)];
  endfunction

  initial begin
    int exp_sc;
    checks           = 0;
    failures         = 0;
    clk_en           = 1'b1;
    SCLK             = 1'b0;
    SRN              = 1'b0;
    bus_if.D         = 1'b0;
    bus_if.SP        = 1'b0;
    bus_if.ALIGN_REQ = 1'b0;
    #12;
    chk("rst_q",        {24'd0, bus_if.Q},        32'd0);
    chk("rst_qvalid",   {31'd0, bus_if.QVALID},   32'd0);
    chk("rst_locked",   {31'd0, bus_if.LOCKED},   32'd0);
    chk("rst_err",      {31'd0, bus_if.ERR},      32'd0);
    chk("rst_slip_cnt", {29'd0, bus_if.SLIP_CNT}, 32'd0);
    SRN = 1'b1;

    // T2: IDLE passthrough, then T5: same words with SP gapped.
    send_word(8'hA5, 1'b0, "t2_w0");
    send_word(8'h3C, 1'b0, "t2_w1");
    send_word(8'hA5, 1'b1, "t5_w0");
    send_word(8'h3C, 1'b1, "t5_w1");

    // T3 alignment (ALIGN_REQ at n=0) and T6 collision (ALIGN_REQ on completion n=98).
    for (int n = 0; n <= 106; n++) begin
      beat(t3_bit(n), 1'b1, (n == 0 || n == 98) ? 1'b1 : 1'b0);
      chk("t3_qvalid", {31'd0, bus_if.QVALID},
          (n == 66 || n == 74 || n == 82 || n == 90) ? 32'd1 : 32'd0);
      chk("t3_locked", {31'd0, bus_if.LOCKED}, (n >= 58 && n < 98) ? 32'd1 : 32'd0);
      exp_sc = (n < 7) ? 0 : (n < 16) ? 1 : (n < 25) ? 2 : (n < 98) ? 3 : 0;
      chk("t3_slip_cnt", {29'd0, bus_if.SLIP_CNT}, exp_sc);
      if (n == 7)  chk("t3_q_first", {24'd0, bus_if.Q}, 32'h14);
      if (n == 16) chk("t3_q_slip1", {24'd0, bus_if.Q}, 32'h69);
      if (n == 66) chk("t3_q_locked", {24'd0, bus_if.Q}, 32'hA5);
      if (n == 98) chk("t6_err", {31'd0, bus_if.ERR}, 32'd0);
    end

    // T4: zeros never match; ERR after the 8th slip, cleared by ALIGN_REQ, then set again on FF.
    for (int m = 0; m <= 142; m++) begin
      beat((m >= 72) ? 1'b1 : 1'b0, 1'b1, (m == 0 || m == 71) ? 1'b1 : 1'b0);
      if (m < 71)      exp_sc = (m < 7) ? 0 : (((m - 7) / 9) + 1) % 8;
      else if (m < 79) exp_sc = 0;
      else             exp_sc = (((m - 79) / 9) + 1) % 8;
      chk("t4_slip_cnt", {29'd0, bus_if.SLIP_CNT}, exp_sc);
      chk("t4_err", {31'd0, bus_if.ERR}, (m == 70 || m >= 142) ? 32'd1 : 32'd0);
      chk("t4_qvalid", {31'd0, bus_if.QVALID}, 32'd0);
      chk("t4_locked", {31'd0, bus_if.LOCKED}, 32'd0);
      if (m == 70)  chk("t4_q_zero", {24'd0, bus_if.Q}, 32'h00);
      if (m == 142) chk("t4_q_ff",   {24'd0, bus_if.Q}, 32'hFF);
    end

    // T1: three bits of a partial word, then async reset with the clock stopped.
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    clk_en = 1'b0;
    #2;
    SRN = 1'b0;
    #1;
    chk("t1_q",        {24'd0, bus_if.Q},        32'd0);
    chk("t1_qvalid",   {31'd0, bus_if.QVALID},   32'd0);
    chk("t1_locked",   {31'd0, bus_if.LOCKED},   32'd0);
    chk("t1_err",      {31'd0, bus_if.ERR},      32'd0);
    chk("t1_slip_cnt", {29'd0, bus_if.SLIP_CNT}, 32'd0);
    #2;
    SRN = 1'b1;
    #2;
    clk_en = 1'b1;
    send_word(8'h3C, 1'b0, "t1_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
